// File: rtl/paddle_controller.sv
`default_nettype none
// ============================================================================
// Module   : paddle_controller
// Purpose  : Turns two raw push-buttons into the paddle's left-edge X pixel.
//            Each button is synchronised (2 flops) and debounced. Once per
//            frame, on the renderer's FRAME_DONE pulse, the paddle moves left
//            or right. Holding a button accelerates the paddle. Its position
//            is clamped between the housing walls.
// Ports    : i_clk            system / pixel clock
//            i_rst_n          asynchronous active-low reset
//            i_btn_left       raw left button, active high, asynchronous
//            i_btn_right      raw right button, active high, asynchronous
//            i_frame_done     one-cycle pulse per frame from the renderer
//            o_paddle_x_pixel registered paddle left edge
//            o_direction      registered state: 00 idle, 01 left, 10 right
//            o_at_wall        registered, high when X sits on either limit
// Revision : 1.0 - initial release
// ============================================================================
module paddle_controller #(
  parameter logic [9:0]  PADDLE_LENGTH_PIXEL = 10'd60,
  parameter logic [9:0]  MIN_X_PIXEL         = 10'd8,
  parameter logic [9:0]  WALL_RIGHT_PIXEL    = 10'd792,
  parameter logic [19:0] DEBOUNCE_CYCLES     = 20'd500000,
  parameter logic [3:0]  SPEED_MIN           = 4'd1,
  parameter logic [3:0]  SPEED_MAX           = 4'd8,
  parameter logic [3:0]  ACCEL_FRAMES        = 4'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_frame_done,
  output logic [9:0] o_paddle_x_pixel,
  output logic [1:0] o_direction,
  output logic       o_at_wall
);

  localparam logic [9:0] c_x_max   = WALL_RIGHT_PIXEL - PADDLE_LENGTH_PIXEL;
  // Paddle centred on an 800-pixel-wide screen.
  localparam logic [9:0] c_x_reset = 10'((11'd800 - {1'b0, PADDLE_LENGTH_PIXEL}) >> 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LEFT  = 2'b01,
    ST_RIGHT = 2'b10
  } state_t;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = left, bit 1 = right
  // --------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_btn_deb;

  assign w_btn_raw = {i_btn_right, i_btn_left};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic        r_meta;
    logic        r_sync;
    logic        r_level;
    logic [19:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_meta  <= 1'b0;
        r_sync  <= 1'b0;
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_meta <= w_btn_raw[g];
        r_sync <= r_meta;
        // Count consecutive cycles where the synced input disagrees with the
        // accepted level; any agreement restarts the count.
        if (r_sync == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
          r_level <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end
    end

    assign w_btn_deb[g] = r_level;
  end

  // --------------------------------------------------------------------------
  // Requested direction
  // --------------------------------------------------------------------------
  state_t w_req;

  always_comb begin
    case (w_btn_deb)
      2'b01:   w_req = ST_LEFT;
      2'b10:   w_req = ST_RIGHT;
      default: w_req = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Movement FSM
  // --------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_x;
  logic [9:0]  w_x_next;
  logic [3:0]  r_speed;
  logic [3:0]  w_speed_next;
  logic [3:0]  r_frame_cnt;
  logic [3:0]  w_frame_cnt_next;
  logic        r_at_wall;
  logic        w_at_wall_next;
  logic [3:0]  w_speed_use;
  logic [3:0]  w_cnt_use;
  logic [10:0] w_sum;
  logic [10:0] w_left_floor;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_x         <= c_x_reset;
      r_speed     <= SPEED_MIN;
      r_frame_cnt <= '0;
      r_at_wall   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_x         <= w_x_next;
      r_speed     <= w_speed_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_at_wall   <= w_at_wall_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_x_next         = r_x;
    w_speed_next     = r_speed;
    w_frame_cnt_next = r_frame_cnt;
    w_at_wall_next   = r_at_wall;
    w_speed_use      = r_speed;
    w_cnt_use        = r_frame_cnt;
    w_sum            = '0;
    w_left_floor     = '0;

    if (i_frame_done) begin
      w_state_next = w_req;
      if (w_req == ST_IDLE) begin
        w_speed_next     = SPEED_MIN;
        w_frame_cnt_next = '0;
      end else begin
        // A fresh press (from idle or a reversal) moves at minimum speed
        // in this very frame.
        if (w_req != r_state) begin
          w_speed_use = SPEED_MIN;
          w_cnt_use   = '0;
        end

        // 11-bit arithmetic keeps the clamp comparisons free of wrap-around.
        if (w_req == ST_LEFT) begin
          w_left_floor = {1'b0, MIN_X_PIXEL} + {7'd0, w_speed_use};
          if ({1'b0, r_x} < w_left_floor) begin
            w_x_next = MIN_X_PIXEL;
          end else begin
            w_x_next = r_x - {6'd0, w_speed_use};
          end
        end else begin
          w_sum = {1'b0, r_x} + {7'd0, w_speed_use};
          if (w_sum > {1'b0, c_x_max}) begin
            w_x_next = c_x_max;
          end else begin
            w_x_next = w_sum[9:0];
          end
        end

        // The frame just moved counts as one held frame. After ACCEL_FRAMES
        // of them the speed steps up for the following frame. Acceleration
        // continues while pinned against a wall.
        if (w_cnt_use == ACCEL_FRAMES - 4'd1) begin
          w_frame_cnt_next = '0;
          w_speed_next     = (w_speed_use < SPEED_MAX) ? w_speed_use + 4'd1 : SPEED_MAX;
        end else begin
          w_frame_cnt_next = w_cnt_use + 4'd1;
          w_speed_next     = w_speed_use;
        end
      end
      w_at_wall_next = (w_x_next == MIN_X_PIXEL) || (w_x_next == c_x_max);
    end
  end

  assign o_paddle_x_pixel = r_x;
  assign o_direction      = r_state;
  assign o_at_wall        = r_at_wall;

endmodule
`default_nettype wire

// File: tb/tb_paddle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddle_controller
// Purpose  : Self-checking bench for paddle_controller (debounce of 4 cycles).
//            A frame-level behavioural model is compared on every cycle.
//            Directed scenarios also carry hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paddle_controller;

  logic       clk;
  logic       rst_n;
  logic       btn_left;
  logic       btn_right;
  logic       frame_done;
  logic [9:0] o_x;
  logic [1:0] o_dir;
  logic       o_wall;

  int n_cmp = 0;
  int n_bad = 0;

  paddle_controller #(
    .PADDLE_LENGTH_PIXEL (10'd60),
    .MIN_X_PIXEL         (10'd8),
    .WALL_RIGHT_PIXEL    (10'd792),
    .DEBOUNCE_CYCLES     (20'd4),
    .SPEED_MIN           (4'd1),
    .SPEED_MAX           (4'd8),
    .ACCEL_FRAMES        (4'd4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_btn_left       (btn_left),
    .i_btn_right      (btn_right),
    .i_frame_done     (frame_done),
    .o_paddle_x_pixel (o_x),
    .o_direction      (o_dir),
    .o_at_wall        (o_wall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model.
  // Debounced level flips after 4 consecutive differing synced samples.
  // The synced value is the raw value seen two edges earlier.
  // Speed depends only on how many frames the same direction has been held:
  // speed = min(8, 1 + held/4).
  // --------------------------------------------------------------------------
  int       m_x    = 370;
  int       m_dir  = 0;
  bit       m_wall = 1'b0;
  int       m_held = 0;
  int       m_req;
  int       m_spd;
  bit [1:0] m_deb  = 2'b00;
  bit [1:0] m_h0   = 2'b00;
  bit [1:0] m_h1   = 2'b00;
  int       m_run[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x    = 370;
      m_dir  = 0;
      m_wall = 1'b0;
      m_held = 0;
      m_deb  = 2'b00;
      m_h0   = 2'b00;
      m_h1   = 2'b00;
      m_run[0] = 0;
      m_run[1] = 0;
    end else begin
      if (frame_done === 1'b1) begin
        m_req = (m_deb == 2'b01) ? 1 : (m_deb == 2'b10) ? 2 : 0;
        if (m_req == 0) begin
          m_held = 0;
        end else begin
          if (m_req != m_dir) m_held = 0;
          m_spd = 1 + m_held / 4;
          if (m_spd > 8) m_spd = 8;
          if (m_req == 1) m_x = (m_x - m_spd < 8) ? 8 : m_x - m_spd;
          else            m_x = (m_x + m_spd > 732) ? 732 : m_x + m_spd;
          m_held++;
        end
        m_dir  = m_req;
        m_wall = (m_x == 8) || (m_x == 732);
      end
      for (int i = 0; i < 2; i++) begin
        if (m_h1[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == 4) begin
            m_deb[i] = m_h1[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_h1 = m_h0;
      m_h0 = {btn_right, btn_left};
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_x",    int'(o_x),    m_x);
    chk("model_dir",  int'(o_dir),  m_dir);
    chk("model_wall", int'(o_wall), int'(m_wall));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after a rising edge)
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame();
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
    tick(1);
  endtask

  task automatic lit(input string name, input int x, input int dir, input int wall);
    chk({name, "_x"},    int'(o_x),    x);
    chk({name, "_dir"},  int'(o_dir),  dir);
    chk({name, "_wall"}, int'(o_wall), wall);
  endtask

  int exp_r[10] = '{371, 372, 373, 374, 376, 378, 380, 382, 385, 388};
  int exp_l[5]  = '{11, 10, 9, 8, 8};
  int exp_lw[5] = '{0, 0, 0, 1, 1};
  int exp_s[6]  = '{731, 730, 729, 728, 726, 724};
  int exp_t[4]  = '{726, 727, 728, 730};

  initial begin
    rst_n      = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    frame_done = 1'b0;
    tick(3);
    lit("reset", 370, 0, 0);
    rst_n = 1'b1;
    tick(1);

    // Idle frames: nothing moves.
    repeat (3) begin
      frame();
      lit("idle", 370, 0, 0);
    end

    // Hold right: accelerate every 4 frames.
    btn_right = 1'b1;
    tick(8);
    for (int i = 0; i < 10; i++) begin
      frame();
      lit("right_accel", exp_r[i], 2, 0);
    end

    // Release, then a 2-cycle glitch on left must be ignored.
    btn_right = 1'b0;
    tick(8);
    frame();
    lit("release", 388, 0, 0);
    btn_left = 1'b1;
    tick(2);
    btn_left = 1'b0;
    tick(8);
    frame();
    lit("glitch", 388, 0, 0);

    // Re-centre, then run left to X=18.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    lit("recentre", 370, 0, 0);
    btn_left = 1'b1;
    tick(8);
    repeat (58) frame();
    lit("left_run", 18, 1, 0);

    // Fresh press from 18: 17,16,15,14 then 12 at speed 2.
    btn_left = 1'b0;
    tick(8);
    frame();
    btn_left = 1'b1;
    tick(8);
    repeat (5) frame();
    lit("left_to12", 12, 1, 0);

    // Fresh press from 12 runs into the left wall without wrapping.
    btn_left = 1'b0;
    tick(8);
    frame();
    lit("idle12", 12, 0, 0);
    btn_left = 1'b1;
    tick(8);
    for (int i = 0; i < 5; i++) begin
      frame();
      lit("left_wall", exp_l[i], 1, exp_lw[i]);
    end

    // Reverse straight to right and run to the right wall.
    btn_left  = 1'b0;
    btn_right = 1'b1;
    tick(8);
    repeat (104) frame();
    lit("right_728", 728, 2, 0);
    frame();
    lit("right_clamp", 732, 2, 1);
    frame();
    lit("right_hold", 732, 2, 1);

    // Both buttons: idle, X frozen.
    btn_left = 1'b1;
    tick(8);
    frame();
    lit("both", 732, 0, 1);
    frame();
    lit("both2", 732, 0, 1);

    // Left only, accelerate, then reverse to right mid-acceleration.
    btn_right = 1'b0;
    tick(8);
    for (int i = 0; i < 6; i++) begin
      frame();
      lit("left_s", exp_s[i], 1, 0);
    end
    btn_left  = 1'b0;
    btn_right = 1'b1;
    tick(8);
    frame();
    lit("rev_right", 725, 2, 0);
    for (int i = 0; i < 4; i++) begin
      frame();
      lit("right_t", exp_t[i], 2, 0);
    end
    btn_left  = 1'b1;
    btn_right = 1'b0;
    tick(8);
    frame();
    lit("rev_left", 729, 1, 0);
    frame();
    lit("left_more", 728, 1, 0);

    // Asynchronous reset in the middle of a frame pulse.
    frame_done = 1'b1;
    rst_n      = 1'b0;
    #1;
    lit("async_reset", 370, 0, 0);
    frame_done = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(8);
    frame();
    lit("after_reset", 369, 1, 0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/paddle_controller.md
Name: paddle_controller

Overview:
- Upstream of the game renderer; produces the paddle's left-edge X pixel consumed by the renderer every frame.
- Synchronises and debounces two raw push-buttons.
- Updates paddle position once per frame on the renderer's FRAME_DONE pulse, with hold-to-accelerate speed, clamped between the housing walls.

Parameters:
PADDLE_LENGTH_PIXEL, 10'd60, paddle width in pixels (must match renderer)
MIN_X_PIXEL, 10'd8, leftmost legal paddle X (first pixel right of left wall tile 0)
WALL_RIGHT_PIXEL, 10'd792, first pixel of right wall tile 99; max X = WALL_RIGHT_PIXEL - PADDLE_LENGTH_PIXEL = 732
DEBOUNCE_CYCLES, 20'd500000, consecutive stable cycles before a button change is accepted (>=2)
SPEED_MIN, 4'd1, pixels/frame on first held frame
SPEED_MAX, 4'd8, saturation speed
ACCEL_FRAMES, 4'd4, held frames per +1 speed step (>=1)

Ports:
CLK  in  1  system/pixel clock
RESET_N  in  1  asynchronous active-low reset
BTN_LEFT  in  1  raw button, active high, asynchronous to CLK
BTN_RIGHT  in  1  raw button, active high, asynchronous to CLK
FRAME_DONE  in  1  one-cycle pulse per frame from renderer
PADDLE_X_PIXEL  out  10  paddle left edge, registered
DIRECTION  out  2  registered FSM state: 00 idle, 01 left, 10 right
AT_WALL  out  1  registered; high when PADDLE_X_PIXEL == MIN_X_PIXEL or == max X

Behaviour:
- Reset (RESET_N low, async): PADDLE_X_PIXEL = (800 - PADDLE_LENGTH_PIXEL)/2 = 370; DIRECTION = 00; AT_WALL = 0; synchronisers, debounce counters, debounced levels, speed = SPEED_MIN, frame counter all cleared/0. Reset asserted mid-movement restores exactly these values; no partial update survives.
- Sync: each button passes a 2-flop synchroniser. Raw-to-debouncer latency is 2 cycles.
- Debounce, per button: a counter runs while synced != debounced level and clears whenever they are equal. When the counter reaches DEBOUNCE_CYCLES-1 the debounced level takes the synced value and the counter clears. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Requested direction from debounced levels: left only -> LEFT; right only -> RIGHT; both or neither -> IDLE.
- FSM states IDLE, LEFT, RIGHT.
  - State changes and position updates occur only on an edge where FRAME_DONE = 1. Between pulses the state is frozen.
  - On a FRAME_DONE edge the next state = requested direction.
  - Entering LEFT/RIGHT from IDLE or from the opposite direction: speed = SPEED_MIN, frame counter = 0. The move applies in that same frame, using SPEED_MIN.
  - Remaining in the same moving state: the move uses the current speed; the frame counter increments.
  - When the frame counter reaches ACCEL_FRAMES-1, it clears and speed increments, saturating at SPEED_MAX. The new speed applies from the next frame.
  - Entering IDLE: no move; speed = SPEED_MIN; counter = 0.
- Arithmetic: computed in 11 bits to avoid wrap.
  - LEFT: X' = max(X - speed, MIN_X_PIXEL).
  - RIGHT: X' = min(X + speed, WALL_RIGHT_PIXEL - PADDLE_LENGTH_PIXEL).
- Output timing: PADDLE_X_PIXEL, DIRECTION and AT_WALL all update on the same edge that samples FRAME_DONE = 1. They are stable for the whole following frame, so there is no mid-frame tearing.
- At a wall while still pushing toward it: X is held, state stays moving, speed keeps accelerating/saturating, AT_WALL = 1.
- FRAME_DONE high on consecutive cycles (not expected): each high cycle is a separate frame update.
- A button change that completes debounce in the same cycle as FRAME_DONE is not seen until the next frame.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then idle 3 FRAME_DONE pulses -> PADDLE_X_PIXEL=370, DIRECTION=00, AT_WALL=0 throughout.
- Hold BTN_RIGHT, ACCEL_FRAMES=4, then 10 frames -> X = 371,372,373,374,376,378,380,382,385,388; DIRECTION=10.
- Pulse BTN_LEFT high for 2 cycles only -> debounced level never rises; X unchanged at next FRAME_DONE.
- Hold BTN_LEFT from X=12 -> X=11,10,9,8,8; AT_WALL=1 from the 4th frame; no underflow wrap.
- Hold right until speed=8 at X=728, then next frame -> X=732 (clamped), AT_WALL=1.
- Both buttons held -> DIRECTION=00, X frozen. Switch right->left mid-acceleration -> first left frame moves 1 px. Assert RESET_N low mid-frame -> X=370 immediately, asynchronously.
